// File: rtl/tlv5638_pkg.sv
// tlv5638_pkg: shared FSM states, TLV5638 command nibbles and default control word.
package tlv5638_pkg;
  typedef enum logic [2:0] {INIT, IDLE, SETUP, SHIFT, GAP} state_t;
  localparam logic [3:0] CMD_A = 4'b1100;
  localparam logic [3:0] CMD_B = 4'b0100;
  localparam logic [15:0] CTRL_WORD_DEF = 16'hD002;
  function automatic logic [15:0] map_cmd(input logic [15:0] rx);
    return {rx[15] ? CMD_A : CMD_B, rx[11:0]};
  endfunction
endpackage

// File: rtl/tlv5638_write_sched_fifo.sv
// word_fifo: 4-deep 16-bit synchronous FIFO with same-cycle push/pop.
module word_fifo (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o,
  output logic        full_o,
  output logic        empty_o
);
  logic [15:0] mem_q [4];
  logic [1:0]  wp_q, rp_q;
  logic [2:0]  cnt_q;
  assign rdata_o = mem_q[rp_q];
  assign full_o  = cnt_q == 3'd4;
  assign empty_o = cnt_q == 3'd0;
  always_ff @(posedge clk)
    if (push_i) mem_q[wp_q] <= wdata_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + 2'd1;
      if (pop_i) rp_q <= rp_q + 2'd1;
      cnt_q <= cnt_q + {2'b0, push_i} - {2'b0, pop_i};
    end
  end
endmodule

// File: rtl/tlv5638_write_sched.sv
// tlv5638_write_sched: queues receiver words and shifts TLV5638 SPI writes, control write first.
// Optional TLV_DUP_FILTER_EN drops FIFO words equal to the last write to the same channel.
module tlv5638_write_sched
  import tlv5638_pkg::*;
#(
  parameter int          CLK_DIV   = 4,
  parameter int          CS_GAP    = 4,
  parameter logic [15:0] CTRL_WORD = CTRL_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] rx_data,
  input  logic        rx_done,
  input  logic        ctrl_req,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_din,
  output logic        busy,
  output logic        word_done,
  output logic        ovf
);
  localparam logic [3:0] DIV_LD = 4'(CLK_DIV - 1);
  localparam logic [3:0] GAP_LD = 4'(CS_GAP - 1);
  state_t      state_q;
  logic [15:0] shreg_q, head;
  logic [3:0]  div_q, bit_q;
  logic        cs_q, sclk_q, din_q, busy_q, wd_q, ovf_q, pend_q;
  logic        full, empty, push, pop, dup, unused_bits;
  assign unused_bits = ^rx_data[14:12];
  assign push = rx_done & ~full;
  assign pop  = (state_q == IDLE) & ~pend_q & ~empty;
  word_fifo u_fifo (
    .clk(clk), .rst(rst), .push_i(push), .pop_i(pop), .wdata_i(map_cmd(rx_data)),
    .rdata_o(head), .full_o(full), .empty_o(empty)
  );
`ifdef TLV_DUP_FILTER_EN
  logic [15:0] sha_q, shb_q;
  assign dup = head[15] ? head == sha_q : head == shb_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sha_q <= '0;
      shb_q <= '0;
    end else if (pop && !dup) begin
      if (head[15]) sha_q <= head;
      else shb_q <= head;
    end
  end
`else
  assign dup = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      shreg_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      din_q   <= 1'b0;
      busy_q  <= 1'b1;
      wd_q    <= 1'b0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      wd_q   <= 1'b0;
      ovf_q  <= ovf_q | (rx_done & full);
      pend_q <= (pend_q & (state_q != IDLE)) | ctrl_req;
      case (state_q)
        INIT: begin
          shreg_q <= CTRL_WORD;
          din_q   <= CTRL_WORD[15];
          cs_q    <= 1'b0;
          div_q   <= DIV_LD;
          state_q <= SETUP;
        end
        IDLE: if (pend_q || (pop && !dup)) begin
          shreg_q <= pend_q ? CTRL_WORD : head;
          din_q   <= pend_q ? CTRL_WORD[15] : head[15];
          cs_q    <= 1'b0;
          div_q   <= DIV_LD;
          busy_q  <= 1'b1;
          state_q <= SETUP;
        end
        SETUP: if (div_q == '0) begin
          sclk_q  <= 1'b0;
          div_q   <= DIV_LD;
          state_q <= SHIFT;
        end else div_q <= div_q - 4'd1;
        SHIFT: if (div_q != '0) div_q <= div_q - 4'd1;
        else if (!sclk_q) begin
          sclk_q <= 1'b1;
          div_q  <= DIV_LD;
          if (bit_q != 4'd15) begin
            shreg_q <= {shreg_q[14:0], 1'b0};
            din_q   <= shreg_q[14];
          end
        end else if (bit_q == 4'd15) begin
          cs_q    <= 1'b1;
          wd_q    <= 1'b1;
          din_q   <= 1'b0;
          bit_q   <= '0;
          div_q   <= GAP_LD;
          state_q <= GAP;
        end else begin
          sclk_q <= 1'b0;
          bit_q  <= bit_q + 4'd1;
          div_q  <= DIV_LD;
        end
        GAP: if (div_q == '0) begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end else div_q <= div_q - 4'd1;
        default: state_q <= INIT;
      endcase
    end
  end
  assign dac_cs_n  = cs_q;
  assign dac_sclk  = sclk_q;
  assign dac_din   = din_q;
  assign busy      = busy_q;
  assign word_done = wd_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_tlv5638_write_sched.sv
// tb_tlv5638_write_sched: directed checks of TLV5638 write sequencing, timing, overflow and reset.
module tb_tlv5638_write_sched;
  logic        clk = 1'b0, rst = 1'b1, rx_done = 1'b0, ctrl_req = 1'b0;
  logic [15:0] rx_data = '0;
  logic        dac_cs_n, dac_sclk, dac_din, busy, word_done, ovf;
  int          checks = 0, errors = 0, wd_cnt = 0, ne = 0, wd0;
  logic [15:0] words[$];
  int          edges[$];
  logic [15:0] sh = '0;
  logic        pcs = 1'b1, psclk = 1'b1;
  always #5 clk = ~clk;
  tlv5638_write_sched dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .ctrl_req(ctrl_req),
    .dac_cs_n(dac_cs_n), .dac_sclk(dac_sclk), .dac_din(dac_din),
    .busy(busy), .word_done(word_done), .ovf(ovf)
  );
  // SPI capture: DAC samples DIN on falling SCLK while CS is low
  always @(negedge clk) begin
    if (word_done) wd_cnt++;
    if (pcs && !dac_cs_n) begin sh = '0; ne = 0; end
    if (!dac_cs_n && psclk && !dac_sclk) begin sh = {sh[14:0], dac_din}; ne++; end
    if (!pcs && dac_cs_n) begin words.push_back(sh); edges.push_back(ne); end
    pcs = dac_cs_n;
    psclk = dac_sclk;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic strobe(input logic [15:0] d);
    rx_data = d;
    rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
  endtask
  task automatic req();
    ctrl_req = 1'b1;
    tick(1);
    ctrl_req = 1'b0;
  endtask
  task automatic expect_word(input string tag, input logic [15:0] exp);
    chk({tag, "_present"}, 32'(words.size() != 0), 1);
    if (words.size() != 0) begin
      chk(tag, 32'(words.pop_front()), 32'(exp));
      chk({tag, "_edges"}, edges.pop_front(), 16);
    end
  endtask
  initial begin
    tick(2);
    chk("rst_cs", dac_cs_n, 1);
    chk("rst_sclk", dac_sclk, 1);
    chk("rst_din", dac_din, 0);
    chk("rst_wd", word_done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 1);
    rst = 1'b0;
    tick(1);
    chk("init_cs_fall", dac_cs_n, 0);
    chk("init_din_msb", dac_din, 1);
    tick(3);
    chk("setup_sclk_hi", dac_sclk, 1);
    tick(1);
    chk("first_fall", dac_sclk, 0);
    tick(127);
    chk("cs_low_132", dac_cs_n, 0);
    tick(1);
    chk("cs_high_133", dac_cs_n, 1);
    chk("wd_133", word_done, 1);
    tick(3);
    chk("busy_gap", busy, 1);
    tick(1);
    chk("idle_busy", busy, 0);
    chk("idle_wd", word_done, 0);
    expect_word("init_ctrl", 16'hD002);
    strobe(16'h8ABC);
    chk("lat_cs_1", dac_cs_n, 1);
    tick(1);
    chk("lat_cs_2", dac_cs_n, 0);
    tick(140);
    expect_word("chan_a", 16'hCABC);
    strobe(16'h0123);
    tick(141);
    expect_word("chan_b", 16'h4123);
    chk("wd_count3", wd_cnt, 3);
    req();
    tick(1);
    strobe(16'h8001);
    strobe(16'h8002);
    strobe(16'h0003);
    strobe(16'h0004);
    strobe(16'h8005);
    strobe(16'h0006);
    chk("ovf_set", ovf, 1);
    tick(720);
    expect_word("burst_ctrl", 16'hD002);
    expect_word("burst_0", 16'hC001);
    expect_word("burst_1", 16'hC002);
    expect_word("burst_2", 16'h4003);
    expect_word("burst_3", 16'h4004);
    chk("burst_extra", words.size(), 0);
    chk("ovf_sticky", ovf, 1);
    strobe(16'h8111);
    tick(2);
    strobe(16'h0222);
    tick(5);
    req();
    tick(10);
    req();
    tick(431);
    expect_word("coal_a", 16'hC111);
    expect_word("coal_ctrl", 16'hD002);
    expect_word("coal_b", 16'h4222);
    chk("coal_extra", words.size(), 0);
    strobe(16'h8333);
    tick(62);
    chk("bit7_low", dac_sclk, 0);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_cs", dac_cs_n, 1);
    chk("mid_rst_sclk", dac_sclk, 1);
    chk("mid_rst_din", dac_din, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_busy", busy, 1);
    rst = 1'b0;
    tick(1);
    chk("reinit_cs", dac_cs_n, 0);
    words.delete();
    edges.delete();
    tick(140);
    expect_word("reinit_ctrl", 16'hD002);
    chk("reinit_extra", words.size(), 0);
    wd0 = wd_cnt;
    strobe(16'h8100);
    tick(141);
    strobe(16'h8100);
    tick(141);
    strobe(16'h0100);
    tick(141);
    expect_word("dup_a", 16'hC100);
`ifdef TLV_DUP_FILTER_EN
    expect_word("dup_b", 16'h4100);
    chk("dup_wd", wd_cnt - wd0, 2);
`else
    expect_word("dup_a2", 16'hC100);
    expect_word("dup_b", 16'h4100);
    chk("dup_wd", wd_cnt - wd0, 3);
`endif
    chk("dup_extra", words.size(), 0);
    chk("dup_ovf", ovf, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
